// File: rtl/sensor_distancia_hcsr04_pkg.sv
// sensor_distancia_hcsr04_pkg: state encoding and default 50 MHz timing constants for the HC-SR04 front-end
package sensor_distancia_hcsr04_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIGGER   = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    TIMEOUT   = 3'd5
  } estado_t;
  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int CYCLES_PER_CM_DEF  = 2941;
  localparam int TIMEOUT_CYCLES_DEF = 1500000;
  localparam int DIST_W_DEF         = 9;
endpackage

// File: rtl/sensor_distancia_hcsr04_contador_cm.sv
// sensor_distancia_hcsr04_contador_cm: sub-cm cycle counter plus saturating cm counter; ports clock/reset, clr, en, dist_rnd (rounded cm)
module sensor_distancia_hcsr04_contador_cm
  import sensor_distancia_hcsr04_pkg::*;
#(
  parameter int CYCLES_PER_CM = CYCLES_PER_CM_DEF,
  parameter int DIST_W        = DIST_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [DIST_W-1:0] dist_rnd
);
  localparam int SUB_W = CYCLES_PER_CM > 1 ? $clog2(CYCLES_PER_CM) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(CYCLES_PER_CM / 2);
  localparam logic [DIST_W-1:0] CM_MAX = '1;
  logic [SUB_W-1:0]  sub;
  logic [DIST_W-1:0] cm;
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      sub <= '0;
      cm  <= '0;
    end else if (en) begin
      sub <= sub == SUB_LAST ? '0 : sub + 1'b1;
      if (sub == SUB_LAST && cm != CM_MAX) cm <= cm + 1'b1;
    end
  end
  // round half up on the leftover fraction, never wrapping past full scale
  assign dist_rnd = (sub >= SUB_HALF && cm != CM_MAX) ? cm + 1'b1 : cm;
endmodule

// File: rtl/sensor_distancia_hcsr04.sv
// sensor_distancia_hcsr04: HC-SR04 trigger/echo timing, cm conversion and range window; ports clock/reset, medir, echo, faixa_min/max -> trigger, distancia, pronto, em_faixa, timeout, ocupado, db_estado
module sensor_distancia_hcsr04
  import sensor_distancia_hcsr04_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int DIST_W         = DIST_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              echo,
  input  logic [DIST_W-1:0] faixa_min,
  input  logic [DIST_W-1:0] faixa_max,
  output logic              trigger,
  output logic [DIST_W-1:0] distancia,
  output logic              pronto,
  output logic              em_faixa,
  output logic              timeout,
  output logic              ocupado,
  output logic [2:0]        db_estado
);
  localparam int TRIG_W = TRIG_CYCLES > 1 ? $clog2(TRIG_CYCLES) : 1;
  localparam int TO_W   = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  estado_t           estado;
  logic              echo_m, echo_s;
  logic [TRIG_W-1:0] trig_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DIST_W-1:0] dist_rnd;
  logic              to_hit;
  assign to_hit    = to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign ocupado   = estado != IDLE;
  assign db_estado = estado;
  sensor_distancia_hcsr04_contador_cm #(
    .CYCLES_PER_CM(CYCLES_PER_CM),
    .DIST_W       (DIST_W)
  ) u_contador_cm (
    .clock   (clock),
    .reset   (reset),
    .clr     (estado == TRIGGER),
    .en      (estado == MEASURE),
    .dist_rnd(dist_rnd)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= IDLE;
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      trig_cnt  <= '0;
      to_cnt    <= '0;
      trigger   <= 1'b0;
      pronto    <= 1'b0;
      em_faixa  <= 1'b0;
      timeout   <= 1'b0;
      distancia <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      pronto <= 1'b0;
      case (estado)
        IDLE: if (medir) begin
          estado   <= TRIGGER;
          trig_cnt <= '0;
          trigger  <= 1'b1;
        end
        TRIGGER: begin
          to_cnt <= '0;
          if (trig_cnt == TRIG_W'(TRIG_CYCLES - 1)) begin
            trigger <= 1'b0;
            estado  <= WAIT_ECHO;
          end else trig_cnt <= trig_cnt + 1'b1;
        end
        WAIT_ECHO: begin
          to_cnt <= to_cnt + 1'b1;
          estado <= to_hit ? TIMEOUT : echo_s ? MEASURE : WAIT_ECHO;
        end
        // timeout wins over a coincident echo fall
        MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          estado <= to_hit ? TIMEOUT : !echo_s ? DONE : MEASURE;
        end
        DONE: begin
          distancia <= dist_rnd;
          em_faixa  <= dist_rnd >= faixa_min && dist_rnd <= faixa_max;
          timeout   <= 1'b0;
          pronto    <= 1'b1;
          estado    <= IDLE;
        end
        TIMEOUT: begin
          distancia <= '1;
          em_faixa  <= 1'b0;
          timeout   <= 1'b1;
          pronto    <= 1'b1;
          estado    <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sensor_distancia_hcsr04.md
Name: sensor_distancia_hcsr04

Overview:
- Ultrasonic ranging front-end that sits directly upstream of the game datapath's "hit the range" check.
- On a one-cycle measure request it:
  - drives the HC-SR04 trigger pulse,
  - times the echo pulse,
  - converts the echo width to centimetres with rounding,
  - classifies the result against a min/max window.
- It returns a one-cycle ready pulse together with the registered distance and an in-range flag that the controller consumes as its range-hit condition.
- A timeout covers a missing or over-long echo.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clocks (10 us at 50 MHz).
- CYCLES_PER_CM, 2941: clocks per centimetre of distance (58.82 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clocks from trigger fall to echo fall (30 ms).
- DIST_W, 9: distance width in cm (saturates at 511).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- medir, in, 1: one-cycle measure request.
- echo, in, 1: asynchronous sensor echo.
- faixa_min, in, DIST_W: lower window bound, inclusive.
- faixa_max, in, DIST_W: upper window bound, inclusive.
- trigger, out, 1: sensor trigger.
- distancia, out, DIST_W: last measured distance in cm.
- pronto, out, 1: one-cycle pulse; distancia, em_faixa and timeout are valid from this cycle.
- em_faixa, out, 1: faixa_min <= distancia <= faixa_max.
- timeout, out, 1: last measurement timed out.
- ocupado, out, 1: measurement in progress (state != IDLE).
- db_estado, out, 3: current state encoding, for debug.

Behaviour:
- One clock domain; reset is synchronous and active-high. Reset overrides everything, including mid-measurement. After the reset edge:
  - state = IDLE,
  - trigger, pronto, em_faixa, timeout, ocupado = 0,
  - distancia = 0,
  - all counters and echo synchroniser flops = 0.
- echo passes through a 2-flop synchroniser (echo_s). All decisions use echo_s; the 2-cycle skew is accepted and not compensated.
- IDLE:
  - medir=1 -> TRIGGER; clear the trigger counter.
  - medir is ignored in every other state; no queuing.
- TRIGGER:
  - trigger=1 for exactly TRIG_CYCLES clocks, then -> WAIT_ECHO.
  - Clear the timeout counter, the cm counter and the sub-counter.
- WAIT_ECHO:
  - The timeout counter increments every clock.
  - echo_s=1 -> MEASURE.
  - Timeout counter reaches TIMEOUT_CYCLES-1 -> TIMEOUT.
- MEASURE:
  - The timeout counter keeps running.
  - The sub-counter counts 0..CYCLES_PER_CM-1; on wrap, the cm counter increments, saturating at 2^DIST_W-1.
  - echo_s=0 -> DONE.
  - Timeout reached first -> TIMEOUT. Timeout has priority if both occur in the same cycle.
- DONE, one cycle:
  - distancia = cm + (sub >= CYCLES_PER_CM/2 ? 1 : 0), saturated.
  - em_faixa is computed from that new value.
  - timeout = 0.
  - pronto = 1 in the next cycle, on return to IDLE.
- TIMEOUT, one cycle:
  - distancia = all ones (saturated).
  - em_faixa = 0, timeout = 1.
  - pronto = 1 in the next cycle, on return to IDLE.
- pronto:
  - High exactly one cycle per accepted medir.
  - It is registered, so it coincides with the first IDLE cycle.
  - medir in that same cycle is accepted.
- distancia, em_faixa and timeout hold their values until the next DONE or TIMEOUT.
- If faixa_min > faixa_max, em_faixa is always 0.
- Latency from medir to trigger rising: 1 clock.
- Zero-width echo (never seen high) behaves as no echo and ends in TIMEOUT.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, TRIGGER=1, WAIT_ECHO=2, MEASURE=3, DONE=4, TIMEOUT=5), so db_estado decodes on the 7-segment debug path;
  - the default timing constants at 50 MHz.
- One natural sub-module: contador_cm. It contains the sub-counter and the saturating cm counter, with clear, enable and rounding output. The FSM stays in the parent.

Test Plan (sim parameters TRIG_CYCLES=5, CYCLES_PER_CM=10, TIMEOUT_CYCLES=1000, DIST_W=9):
- Reset and trigger timing: assert reset 3 cycles, then medir pulse -> all outputs 0 after reset; trigger high exactly 5 cycles starting 1 cycle after medir; ocupado=1 throughout the measurement.
- Rounding: echo high 250, 254 and 255 cycles in three measurements -> distancia 25, 25 and 26; one pronto pulse each; timeout=0.
- Window: faixa_min=20, faixa_max=30 with echoes giving 19, 20, 30, 31 cm -> em_faixa 0, 1, 1, 0. With faixa_min=40, faixa_max=10 -> em_faixa always 0.
- No echo: echo held low -> pronto 1000 cycles after trigger fall (± synchroniser/transition cycles); timeout=1, distancia=511, em_faixa=0.
- Over-long echo and saturation:
  - echo high 2000 cycles -> TIMEOUT path with timeout=1.
  - With TIMEOUT_CYCLES=10000, echo 6000 cycles -> distancia saturates at 511.
- Reset mid-measurement and extra requests: reset in MEASURE -> next cycle state IDLE and trigger=0, no pronto. A medir issued while ocupado=1 is ignored, giving exactly one pronto.
